dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one synchronous single-port data memory between NUM_CORES processor cores. Each core's control FSM raises a load or store request.
- Grants are round-robin; one access is serviced at a time.
- Sits between the per-core memory-access ports and the shared data RAM in the multi-core top level.
- Each access takes 3 cycles: arbitrate, memory access, response/acknowledge.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 8, data-memory address width
- DATA_W, 16, data word width
- CNT_W, 16, width of the per-core grant counters (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- core_req  in  NUM_CORES  per-core request level, held until ack
- core_we  in  NUM_CORES  1 = store, 0 = load
- core_addr  in  NUM_CORES*ADDR_W  flattened addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened store data
- core_ack  out  NUM_CORES  one-hot, 1-cycle completion pulse
- core_rdata  out  DATA_W  load data broadcast to all cores, valid with core_ack
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
- busy  out  1  high in ACCESS and RESP
- grant_id  out  clog2(NUM_CORES)  index of the core currently served
- grant_cnt  out  NUM_CORES*CNT_W  only with DMEM_ARB_STATS_EN

Behaviour:
- Reset: all outputs registered and zero after reset. State is IDLE, rr_ptr=0, mask=0.
- Reset asserted in any state aborts the access. No ack is issued. mem_en is 0 from the next cycle.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - eligible = core_req & ~mask.
  - If eligible is nonzero, winner = first set bit searching upward from rr_ptr, wrapping at NUM_CORES-1 to 0.
  - Latch winner into grant_id, and latch its we, addr and wdata. Go to ACCESS.
  - Otherwise stay in IDLE.
  - mask is cleared at the end of every IDLE cycle.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata come from the latched values.
  - Lasts exactly 1 cycle, then go to RESP.
- RESP:
  - mem_en=0. core_ack[grant_id]=1 for this cycle only.
  - For a load, core_rdata = mem_rdata. For a store, core_rdata holds its previous value.
  - rr_ptr = (grant_id+1) mod NUM_CORES.
  - mask = one-hot(grant_id), so the just-acked core cannot win in the following IDLE cycle.
  - Go to IDLE.
- Throughput: one access every 3 cycles per grant.
- Latency from req seen in IDLE to ack is 2 cycles, assuming the core wins.
- Request inputs are sampled only in IDLE. A change to core_addr, core_wdata or core_we after the grant has no effect on the current access.
- A core dropping req before ack is a protocol violation; the access still completes and ack is still pulsed.
- Simultaneous requests are resolved only by rr_ptr. No core waits more than NUM_CORES-1 foreign grants.
- When only the masked core requests, IDLE idles one cycle, then grants it.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Per-core grant_cnt[i] increments in RESP when grant_id==i.
  - Counters saturate at all-ones and reset to 0 on rst.
- Undefined:
  - grant_cnt port and counters are absent.
  - Arbitration timing is identical in both builds.

Decomposition:
- dmem_arb_pkg holds the state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and default widths.
- One sub-module, rr_picker: combinational round-robin priority encoder. Inputs are eligible vector and rr_ptr. Outputs are winner index and a valid flag.
- Top holds the FSM, latches, mask and counters.

Test Plan:
- Single load: core 2 req, we=0, addr=0x10; memory returns 0xBEEF. Expect mem_en=1 with mem_addr=0x10 one cycle after IDLE sample. Next cycle core_ack=4'b0100 and core_rdata=0xBEEF. rr_ptr becomes 3.
- Store: core 1 we=1, addr=0x20, wdata=0x1234. Expect mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x1234 in ACCESS. core_ack=4'b0010 next cycle. core_rdata unchanged.
- Contention: all four cores request from reset (rr_ptr=0), each dropping req on its ack. Expect acks in order 0,1,2,3, spaced 3 cycles apart, with busy low exactly one cycle between accesses.
- Fairness/mask: core 0 holds req continuously (re-requests immediately) and core 3 requests at cycle 5. Expect core 3 acked after at most one further core-0 access, and never two consecutive core-0 grants while core 3 waits.
- Reset mid-access: assert rst during ACCESS. Expect no core_ack, mem_en=0 the next cycle, and the first grant after reset goes to the lowest requesting index.
- Stats (DMEM_ARB_STATS_EN): after the contention test, expect grant_cnt = 1 for every core. Force CNT_W=2 with 5 core-0 grants and expect a saturated count of 3.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and default widths.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first eligible index at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] eligible,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    int idx;

    // Walk offsets from farthest to nearest so the closest eligible index to rr_ptr wins last.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (eligible[IDX_W'(idx)]) winner = IDX_W'(idx);
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data RAM between NUM_CORES cores.
// Optional per-core saturating grant counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GID_W     = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [NUM_CORES*CNT_W-1:0]    grant_cnt
`endif
);

    arb_state_e state_q, state_d;

    logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;
    logic [NUM_CORES-1:0]             mask_q;
    logic [NUM_CORES-1:0]             eligible;
    logic [NUM_CORES-1:0]             gid_oh;
    logic [GID_W-1:0]                 rr_ptr_q;
    logic [GID_W-1:0]                 rr_next;
    logic [GID_W-1:0]                 pick_id;
    logic                             pick_vld;
    logic                             ld_q;
    logic [DATA_W-1:0]                rdata_q;

    assign addr_v   = core_addr;
    assign wdata_v  = core_wdata;
    assign eligible = core_req & ~mask_q;
    assign gid_oh   = NUM_CORES'(1) << grant_id;
    assign rr_next  = (grant_id == GID_W'(NUM_CORES - 1)) ? '0 : grant_id + GID_W'(1);

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (GID_W)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .winner   (pick_id),
        .valid    (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            mask_q    <= '0;
            grant_id  <= '0;
            ld_q      <= 1'b0;
            rdata_q   <= '0;
            core_ack  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d != IDLE);
            mem_en   <= (state_d == ACCESS);
            core_ack <= '0;
            case (state_q)
                IDLE: begin
                    mask_q <= '0;
                    if (pick_vld) begin
                        grant_id  <= pick_id;
                        ld_q      <= ~core_we[pick_id];
                        mem_we    <= core_we[pick_id];
                        mem_addr  <= addr_v[pick_id];
                        mem_wdata <= wdata_v[pick_id];
                    end
                end
                ACCESS: begin
                    mem_we   <= 1'b0;
                    core_ack <= gid_oh;
                end
                RESP: begin
                    if (ld_q) rdata_q <= mem_rdata;
                    rr_ptr_q <= rr_next;
                    mask_q   <= gid_oh;
                end
                default: ;
            endcase
        end
    end

    // The RAM only presents load data during RESP, so it is forwarded there and held afterwards.
    assign core_rdata = (state_q == RESP && ld_q) ? mem_rdata : rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [NUM_CORES-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == RESP) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (gid_oh[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a synchronous RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  core_req;
    logic [3:0]  core_we;
    logic [31:0] core_addr;
    logic [63:0] core_wdata;
    logic [3:0]  core_ack;
    logic [15:0] core_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [1:0]  grant_id;
`ifdef DMEM_ARB_STATS_EN
    logic [7:0]  grant_cnt;
`endif

    logic [15:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    dmem_arbiter #(
        .NUM_CORES (4),
        .ADDR_W    (8),
        .DATA_W    (16),
        .CNT_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .grant_id   (grant_id)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    task automatic set_core(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
        core_we[i]            = we;
        core_addr[i*8 +: 8]   = a;
        core_wdata[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        core_req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (core_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0000", core_ack); end
        n_checks++; if (core_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", core_rdata); end
        n_checks++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_ctl got %b want 00", {mem_en, mem_we}); end
        n_checks++; if ({mem_addr, mem_wdata} !== 24'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata}); end
        n_checks++; if ({busy, grant_id} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_gid got %b want 000", {busy, grant_id}); end
        rst = 1'b0;
    endtask

    task automatic test_single_load();
        mem[8'h10] = 16'hBEEF;
        set_core(2, 1'b0, 8'h10, 16'h0);
        core_req = 4'b0100;
        @(negedge clk);
        n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h10}) begin n_fail++; $display("FAIL load_access got en/we/addr %b%b/%h want 10/10", mem_en, mem_we, mem_addr); end
        n_checks++; if ({busy, grant_id, core_ack} !== {1'b1, 2'd2, 4'b0}) begin n_fail++; $display("FAIL load_grant got busy %b gid %0d ack %b want 1 2 0000", busy, grant_id, core_ack); end
        @(negedge clk);
        n_checks++; if (core_ack !== 4'b0100) begin n_fail++; $display("FAIL load_ack got %b want 0100", core_ack); end
        n_checks++; if (core_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL load_rdata got %h want beef", core_rdata); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL load_resp_en got %b want 0", mem_en); end
        core_req = 4'b0;
        @(negedge clk);
        n_checks++; if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL load_rr_ptr got %0d want 3", dut.rr_ptr_q); end
        n_checks++; if ({busy, core_ack} !== 5'b0) begin n_fail++; $display("FAIL load_idle got busy %b ack %b want 0 0000", busy, core_ack); end
    endtask

    task automatic test_store();
        set_core(1, 1'b1, 8'h20, 16'h1234);
        core_req = 4'b0010;
        @(negedge clk);
        n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h20, 16'h1234}) begin n_fail++; $display("FAIL store_access got %b%b %h %h want 11 20 1234", mem_en, mem_we, mem_addr, mem_wdata); end
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL store_gid got %0d want 1", grant_id); end
        set_core(1, 1'b0, 8'h55, 16'hAAAA);
        @(negedge clk);
        n_checks++; if (core_ack !== 4'b0010) begin n_fail++; $display("FAIL store_ack got %b want 0010", core_ack); end
        n_checks++; if (core_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL store_rdata_hold got %h want beef", core_rdata); end
        n_checks++; if (mem[8'h20] !== 16'h1234) begin n_fail++; $display("FAIL store_mem got %h want 1234", mem[8'h20]); end
        core_req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [3:0] exp_ack;
        logic       exp_busy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem[8'h30 + i] = 16'hC000 + 16'(i);
            set_core(i, 1'b0, 8'h30 + 8'(i), 16'h0);
        end
        core_req = 4'b1111;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            exp_ack  = (cyc % 3 == 2) ? (4'b0001 << ((cyc - 2) / 3)) : 4'b0000;
            exp_busy = (cyc % 3 != 0);
            n_checks++; if (core_ack !== exp_ack) begin n_fail++; $display("FAIL contention_ack cyc %0d got %b want %b", cyc, core_ack, exp_ack); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL contention_busy cyc %0d got %b want %b", cyc, busy, exp_busy); end
            core_req = core_req & ~core_ack;
        end
`ifdef DMEM_ARB_STATS_EN
        n_checks++; if (grant_cnt !== 8'b01_01_01_01) begin n_fail++; $display("FAIL stats_contention got %b want 01010101", grant_cnt); end
`endif
    endtask

    // Core 0 alone keeps requesting: every grant is followed by a masked idle cycle, so a 4-cycle period.
    task automatic test_masked_solo();
        int acks = 0;
        core_req = 4'b0001;
        for (int cyc = 1; cyc <= 40 && acks < 5; cyc++) begin
            @(negedge clk);
            if (core_ack[0]) begin
                n_checks++; if (cyc !== 2 + 4 * acks) begin n_fail++; $display("FAIL solo_ack_time ack %0d got cyc %0d want %0d", acks, cyc, 2 + 4 * acks); end
                acks++;
            end
            if (acks == 5) core_req = 4'b0;
        end
        n_checks++; if (acks !== 5) begin n_fail++; $display("FAIL solo_ack_count got %0d want 5", acks); end
        core_req = 4'b0;
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        n_checks++; if (grant_cnt[1:0] !== 2'd3) begin n_fail++; $display("FAIL stats_saturate got %0d want 3", grant_cnt[1:0]); end
`endif
    endtask

    task automatic test_fairness();
        int ack3_cyc = 0;
        int w0       = 0;
        do_reset();
        core_req = 4'b0001;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (core_req[3] && core_ack[0]) w0++;
            if (core_ack[3] && ack3_cyc == 0) begin
                ack3_cyc    = cyc;
                core_req[3] = 1'b0;
            end
            if (cyc == 5) core_req[3] = 1'b1;
        end
        n_checks++; if (ack3_cyc !== 9) begin n_fail++; $display("FAIL fair_ack3_cycle got %0d want 9", ack3_cyc); end
        n_checks++; if (w0 > 1) begin n_fail++; $display("FAIL fair_core0_while_wait got %0d want <=1", w0); end
        core_req = 4'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_core(2, 1'b0, 8'h11, 16'h0);
        core_req = 4'b0100;
        repeat (2) @(negedge clk);
        core_req = 4'b0;
        @(negedge clk);
        set_core(1, 1'b0, 8'h41, 16'h0);
        set_core(3, 1'b0, 8'h43, 16'h0);
        core_req = 4'b1010;
        @(negedge clk);
        n_checks++; if ({mem_en, grant_id} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL rst_mid_pre got en %b gid %0d want 1 3", mem_en, grant_id); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_en, busy, core_ack} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_abort got en %b busy %b ack %b want 0 0 0000", mem_en, busy, core_ack); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({mem_en, grant_id, mem_addr} !== {1'b1, 2'd1, 8'h41}) begin n_fail++; $display("FAIL rst_mid_regrant got en %b gid %0d addr %h want 1 1 41", mem_en, grant_id, mem_addr); end
        n_checks++; if (core_ack !== 4'b0) begin n_fail++; $display("FAIL rst_mid_noack got %b want 0000", core_ack); end
        @(negedge clk);
        n_checks++; if (core_ack !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_ack got %b want 0010", core_ack); end
        core_req = 4'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        mem_rdata  = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_masked_solo();
        test_fairness();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
